// File: rtl/ac_avalon_master.sv
// rtl/ac_avalon_master.sv - Avalon-MM master for the audio codec: init/readback sequence, then host command bridge.
// All outputs are registered; the state register names the bus phase visible in the current cycle.
module ac_avalon_master #(
  parameter int unsigned INIT_SRC_L = 4,
  parameter int unsigned INIT_SRC_R = 4,
  parameter logic [15:0] INIT_FRQ_L = 16'h0400,
  parameter logic [15:0] INIT_FRQ_R = 16'h0800,
  parameter bit          INIT_EN    = 1'b1,
  parameter bit          INIT_MUTE  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  mAdr,
  output logic        mWr,
  output logic [15:0] mWrData,
  output logic        mRd,
  input  logic [15:0] mRdData,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic        cmdWr,
  input  logic [1:0]  cmdAdr,
  input  logic [15:0] cmdData,
  output logic        rspValid,
  output logic [15:0] rspData,
  output logic        initDone,
  output logic        initErr
);

  localparam logic [2:0]  SRC_L     = INIT_SRC_L[2:0];
  localparam logic [2:0]  SRC_R     = INIT_SRC_R[2:0];
  localparam logic [15:0] ADR1_VAL  = {9'b0, SRC_R, 1'b0, SRC_L};
  localparam logic [15:0] ADR0_VAL  = {INIT_EN, INIT_MUTE, 14'b0};
  localparam logic [2:0]  LAST_STEP = 3'd4;

  typedef enum logic [2:0] {
    INIT_WR, INIT_RD, INIT_WAIT, READY, CMD_WR, CMD_RD, CMD_WAIT, CMD_RSP
  } state_t;

  state_t     state;
  logic [2:0] step;

  // Step 0 is the soft reset; steps 1..4 are the configuration writes that get read back.
  function automatic logic [15:0] init_data(input logic [2:0] s);
    case (s)
      3'd0:    return 16'h0001;
      3'd1:    return ADR1_VAL;
      3'd2:    return INIT_FRQ_L;
      3'd3:    return INIT_FRQ_R;
      default: return ADR0_VAL;
    endcase
  endfunction

  function automatic logic [1:0] init_adr(input logic [2:0] s);
    return (s == LAST_STEP) ? 2'd0 : s[1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT_WR;
      step     <= 3'd0;
      mAdr     <= 2'd0;
      mWr      <= 1'b0;
      mWrData  <= 16'h0000;
      mRd      <= 1'b0;
      cmdReady <= 1'b0;
      rspValid <= 1'b0;
      rspData  <= 16'h0000;
      initDone <= 1'b0;
      initErr  <= 1'b0;
    end else begin
      case (state)
        INIT_WR: begin
          // mWr is low only on the very first cycle out of reset.
          if (!mWr) begin
            mWr     <= 1'b1;
            mAdr    <= init_adr(3'd0);
            mWrData <= init_data(3'd0);
          end else if (step != LAST_STEP) begin
            step    <= step + 3'd1;
            mAdr    <= init_adr(step + 3'd1);
            mWrData <= init_data(step + 3'd1);
          end else begin
            mWr   <= 1'b0;
            mRd   <= 1'b1;
            step  <= 3'd1;
            mAdr  <= init_adr(3'd1);
            state <= INIT_RD;
          end
        end
        INIT_RD: begin
          mRd   <= 1'b0;
          state <= INIT_WAIT;
        end
        INIT_WAIT: begin
          if (mRdData != init_data(step)) initErr <= 1'b1;
          if (step == LAST_STEP) begin
            initDone <= 1'b1;
            cmdReady <= 1'b1;
            state    <= READY;
          end else begin
            step  <= step + 3'd1;
            mRd   <= 1'b1;
            mAdr  <= init_adr(step + 3'd1);
            state <= INIT_RD;
          end
        end
        READY, CMD_RSP: begin
          // The response cycle also accepts, giving back-to-back commands.
          rspValid <= 1'b0;
          rspData  <= 16'h0000;
          if (cmdValid) begin
            cmdReady <= 1'b0;
            mAdr     <= cmdAdr;
            if (cmdWr) begin
              mWr     <= 1'b1;
              mWrData <= cmdData;
              state   <= CMD_WR;
            end else begin
              mRd   <= 1'b1;
              state <= CMD_RD;
            end
          end else begin
            state <= READY;
          end
        end
        CMD_WR: begin
          mWr      <= 1'b0;
          rspValid <= 1'b1;
          rspData  <= 16'h0000;
          cmdReady <= 1'b1;
          state    <= CMD_RSP;
        end
        CMD_RD: begin
          mRd   <= 1'b0;
          state <= CMD_WAIT;
        end
        CMD_WAIT: begin
          rspValid <= 1'b1;
          rspData  <= mRdData;
          cmdReady <= 1'b1;
          state    <= CMD_RSP;
        end
        default: state <= INIT_WR;
      endcase
    end
  end

endmodule

// File: tb/tb_ac_avalon_master.sv
// tb/tb_ac_avalon_master.sv - directed init/command/reset checks plus a random command stream against a register-file reference.
module tb_ac_avalon_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  mAdr;
  logic        mWr;
  logic [15:0] mWrData;
  logic        mRd;
  logic [15:0] mRdData;
  logic        cmdValid;
  logic        cmdReady;
  logic        cmdWr;
  logic [1:0]  cmdAdr;
  logic [15:0] cmdData;
  logic        rspValid;
  logic [15:0] rspData;
  logic        initDone;
  logic        initErr;

  // Second instance with an illegal left source code; its command port stays idle.
  logic [1:0]  b_mAdr;
  logic        b_mWr;
  logic [15:0] b_mWrData;
  logic        b_mRd;
  logic [15:0] b_mRdData;
  logic        b_cmdValid = 1'b0;
  logic        b_cmdReady;
  logic        b_cmdWr = 1'b0;
  logic [1:0]  b_cmdAdr = 2'd0;
  logic [15:0] b_cmdData = 16'h0000;
  logic        b_rspValid;
  logic [15:0] b_rspData;
  logic        b_initDone;
  logic        b_initErr;

  int total = 0;
  int bad   = 0;

  ac_avalon_master dut (
    .clk(clk), .reset(reset), .mAdr(mAdr), .mWr(mWr), .mWrData(mWrData), .mRd(mRd),
    .mRdData(mRdData), .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWr(cmdWr),
    .cmdAdr(cmdAdr), .cmdData(cmdData), .rspValid(rspValid), .rspData(rspData),
    .initDone(initDone), .initErr(initErr)
  );

  ac_avalon_master #(.INIT_SRC_L(6)) dut_bad (
    .clk(clk), .reset(reset), .mAdr(b_mAdr), .mWr(b_mWr), .mWrData(b_mWrData), .mRd(b_mRd),
    .mRdData(b_mRdData), .cmdValid(b_cmdValid), .cmdReady(b_cmdReady), .cmdWr(b_cmdWr),
    .cmdAdr(b_cmdAdr), .cmdData(b_cmdData), .rspValid(b_rspValid), .rspData(b_rspData),
    .initDone(b_initDone), .initErr(b_initErr)
  );

  // Slave: four registers, read latency 1; adr1 keeps only the two source fields, illegal codes stored as 0.
  logic [15:0] mem_a [4];
  logic [15:0] mem_b [4];
  logic [15:0] rd_a;
  logic [15:0] rd_b;
  assign mRdData   = rd_a;
  assign b_mRdData = rd_b;

  function automatic logic [15:0] slave_store(input logic [1:0] a, input logic [15:0] d);
    logic [2:0] l, r;
    if (a != 2'd1) return d;
    l = (d[2:0] > 3'd4) ? 3'd0 : d[2:0];
    r = (d[6:4] > 3'd4) ? 3'd0 : d[6:4];
    return {9'b0, r, 1'b0, l};
  endfunction

  always @(posedge clk) begin
    if (mWr) mem_a[mAdr] <= slave_store(mAdr, mWrData);
    if (mRd) rd_a <= mem_a[mAdr];
    if (b_mWr) mem_b[b_mAdr] <= slave_store(b_mAdr, b_mWrData);
    if (b_mRd) rd_b <= mem_b[b_mAdr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) chk("wr_rd_exclusive", 32'(mWr & mRd), 32'd0);

  int          exp_wadr  [5] = '{0, 1, 2, 3, 0};
  logic [15:0] exp_wdata [5] = '{16'h0001, 16'h0044, 16'h0400, 16'h0800, 16'h8000};

  // Caller leaves the bench in cycle 0 (reset just released); returns in cycle 14.
  task automatic check_init();
    bit exp_wr, exp_rd;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp_wr = (k <= 5);
      exp_rd = (k >= 6) && (k <= 12) && (k % 2 == 0);
      chk("init_mwr", 32'(mWr), 32'(exp_wr));
      chk("init_mrd", 32'(mRd), 32'(exp_rd));
      if (exp_wr) begin
        chk("init_wadr", 32'(mAdr), 32'(exp_wadr[k-1]));
        chk("init_wdata", 32'(mWrData), 32'(exp_wdata[k-1]));
      end
      if (exp_rd) chk("init_radr", 32'(mAdr), 32'(exp_wadr[(k-4)/2]));
      chk("init_done", 32'(initDone), 32'(k == 14));
      chk("init_ready", 32'(cmdReady), 32'(k == 14));
      chk("init_no_rsp", 32'(rspValid), 32'd0);
    end
    chk("init_err_clean", 32'(initErr), 32'd0);
    chk("bad_src_done", 32'(b_initDone), 32'd1);
    chk("bad_src_err", 32'(b_initErr), 32'd1);
  endtask

  int          model [4];
  logic [15:0] exp_q [$];
  int          accepted, responses, cyc, l, r;

  initial begin
    reset = 1'b1; cmdValid = 1'b0; cmdWr = 1'b0; cmdAdr = 2'd0; cmdData = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({mWr, mRd, mAdr, mWrData, cmdReady, rspValid, initDone, initErr}), 32'd0);
    chk("rst_rspdata", 32'(rspData), 32'd0);
    chk("rst_bad_err", 32'(b_initErr), 32'd0);

    // Command held valid throughout init must wait until READY.
    reset = 1'b0; cmdValid = 1'b1; cmdWr = 1'b1; cmdAdr = 2'd2; cmdData = 16'h1234;
    check_init();

    @(negedge clk);
    chk("wr_mwr", 32'(mWr), 32'd1);
    chk("wr_madr", 32'(mAdr), 32'd2);
    chk("wr_data", 32'(mWrData), 32'h1234);
    chk("wr_busy", 32'(cmdReady), 32'd0);
    cmdValid = 1'b0;
    @(negedge clk);
    chk("wr_rsp", 32'(rspValid), 32'd1);
    chk("wr_rspdata", 32'(rspData), 32'd0);
    chk("wr_ready_again", 32'(cmdReady), 32'd1);
    cmdValid = 1'b1; cmdWr = 1'b0; cmdAdr = 2'd2;
    @(negedge clk);
    chk("rd_mrd", 32'(mRd), 32'd1);
    chk("rd_madr", 32'(mAdr), 32'd2);
    chk("rd_no_rsp_a1", 32'(rspValid), 32'd0);
    cmdValid = 1'b0;
    @(negedge clk);
    chk("rd_no_rsp_a2", 32'(rspValid), 32'd0);
    @(negedge clk);
    chk("rd_rsp", 32'(rspValid), 32'd1);
    chk("rd_rspdata", 32'(rspData), 32'h1234);

    // Reset lands on the mRd cycle of a host read.
    cmdValid = 1'b1; cmdWr = 1'b0; cmdAdr = 2'd3;
    @(negedge clk);
    chk("abort_mrd", 32'(mRd), 32'd1);
    reset = 1'b1; cmdValid = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 32'({mWr, mRd, mAdr, mWrData, cmdReady, rspValid, initDone, initErr}), 32'd0);
    reset = 1'b0;
    check_init();

    model[0] = 32'(exp_wdata[4]);
    model[1] = 32'(exp_wdata[1]);
    model[2] = 32'(exp_wdata[2]);
    model[3] = 32'(exp_wdata[3]);
    accepted = 0; responses = 0; cyc = 0;
    while ((accepted < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (rspValid) begin
        chk("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("rsp_data", 32'(rspData), 32'(exp_q.pop_front()));
        responses++;
      end
      if (accepted < 1000) begin
        cmdValid = ($urandom_range(0, 3) != 0);
        cmdWr    = 1'($urandom_range(0, 1));
        cmdAdr   = 2'($urandom_range(0, 3));
        cmdData  = 16'($urandom);
        if (cmdValid && cmdReady) begin
          accepted++;
          if (cmdWr) begin
            if (cmdAdr == 2'd1) begin
              l = cmdData % 8;
              r = (cmdData / 16) % 8;
              if (l > 4) l = 0;
              if (r > 4) r = 0;
              model[1] = r * 16 + l;
            end else begin
              model[cmdAdr] = cmdData;
            end
            exp_q.push_back(16'h0000);
          end else begin
            exp_q.push_back(16'(model[cmdAdr]));
          end
        end
      end else begin
        cmdValid = 1'b0;
      end
    end
    chk("rand_in_budget", 32'(cyc < 20000), 32'd1);
    chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("rand_rsp_count", 32'(responses), 32'd1000);
    repeat (3) @(negedge clk);
    chk("rand_no_extra_rsp", 32'(rspValid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
